// File: rtl/seven_seg_capture_if.sv
// Scan lines observed from the display driver plus the
// decoded frame and status published by the capture monitor.
interface seven_seg_capture_if;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic [15:0] value;
    logic        frame_valid;
    logic        locked;
    logic        seq_error;
    logic        decode_error;

    modport master (
        output anode,
        output cathode,
        input  value,
        input  frame_valid,
        input  locked,
        input  seq_error,
        input  decode_error
    );

    modport slave (
        input  anode,
        input  cathode,
        output value,
        output frame_valid,
        output locked,
        output seq_error,
        output decode_error
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Seven-segment scan monitor: debounces anode/cathode, decodes
// glyphs to nibbles and publishes in-order 0..3 frames.
module seven_seg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    seven_seg_capture_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    typedef enum logic {S_HUNT, S_TRACK} state_t;

    logic [3:0]    r_anode;
    logic [6:0]    r_cathode;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    state_t        r_state;
    logic [1:0]    r_exp;
    logic [1:0]    r_last;
    logic [15:0]   r_digits;
    logic [15:0]   r_value;
    logic          r_fv;
    logic          r_seq;
    logic          r_dec;

    logic          w_diff;
    logic          w_commit;
    logic [6:0]    w_seg;
    logic          w_glyph_ok;
    logic [3:0]    w_nib;
    logic          w_idle;
    logic          w_legal;
    logic [1:0]    w_idx;

    state_t        w_n_state;
    logic [1:0]    w_n_exp;
    logic [1:0]    w_n_last;
    logic [15:0]   w_n_digits;
    logic [15:0]   w_n_value;
    logic          w_n_fv;
    logic          w_n_seq;
    logic          w_n_dec;

    assign w_diff   = {bus.anode, bus.cathode} != {r_anode, r_cathode};
    // One commit per stable period: r_done blocks repeats once saturated.
    assign w_commit = (r_cnt == C_MAX) && !r_done;

    // Sample register and stability counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_anode   <= 4'hF;
            r_cathode <= 7'h7F;
            r_cnt     <= C_MAX;
            r_done    <= 1'b1;
        end else begin
            r_anode   <= bus.anode;
            r_cathode <= bus.cathode;
            if (w_diff) begin
                r_cnt  <= C_ONE;
                r_done <= 1'b0;
            end else begin
                if (r_cnt != C_MAX) r_cnt <= r_cnt + C_ONE;
                if (w_commit) r_done <= 1'b1;
            end
        end
    end

    // Glyph decode of the committed segment pattern (active-high gfedcba).
    always_comb begin
        w_seg      = ~r_cathode;
        w_glyph_ok = 1'b1;
        w_nib      = 4'h0;
        case (w_seg)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            default: w_glyph_ok = 1'b0;
        endcase
    end

    // Anode classification: idle, single digit, or illegal.
    always_comb begin
        w_idle  = 1'b0;
        w_legal = 1'b0;
        w_idx   = 2'd0;
        case (r_anode)
            4'b1111: w_idle = 1'b1;
            4'b1110: begin w_legal = 1'b1; w_idx = 2'd0; end
            4'b1101: begin w_legal = 1'b1; w_idx = 2'd1; end
            4'b1011: begin w_legal = 1'b1; w_idx = 2'd2; end
            4'b0111: begin w_legal = 1'b1; w_idx = 2'd3; end
            default: ;
        endcase
    end

    // Sequencing FSM: next state, digit capture and frame publish.
    always_comb begin
        w_n_state  = r_state;
        w_n_exp    = r_exp;
        w_n_last   = r_last;
        w_n_digits = r_digits;
        w_n_value  = r_value;
        w_n_fv     = 1'b0;
        w_n_seq    = r_seq;
        w_n_dec    = r_dec;
        if (w_commit && !w_idle) begin
            if (!w_legal) begin
                w_n_seq   = 1'b1;
                w_n_state = S_HUNT;
            end else begin
                w_n_last = w_idx;
                if (!w_glyph_ok) begin
                    w_n_dec   = 1'b1;
                    w_n_state = S_HUNT;
                end else if (r_state == S_HUNT) begin
                    w_n_digits[{w_idx, 2'b00} +: 4] = w_nib;
                    if (w_idx == 2'd0) begin
                        w_n_state = S_TRACK;
                        w_n_exp   = 2'd1;
                    end
                end else if (w_idx == r_exp) begin
                    w_n_digits[{w_idx, 2'b00} +: 4] = w_nib;
                    w_n_exp = r_exp + 2'd1;
                    if (w_idx == 2'd3) begin
                        w_n_value = w_n_digits;
                        w_n_fv    = 1'b1;
                    end
                end else if (w_idx == r_last) begin
                    // Cathode changed while the same digit stayed on.
                    w_n_digits[{w_idx, 2'b00} +: 4] = w_nib;
                end else begin
                    w_n_seq = 1'b1;
                    if (w_idx == 2'd0) begin
                        w_n_digits[{w_idx, 2'b00} +: 4] = w_nib;
                        w_n_exp = 2'd1;
                    end else begin
                        w_n_state = S_HUNT;
                    end
                end
            end
        end
    end

    // State, digit and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_HUNT;
            r_exp    <= 2'd0;
            r_last   <= 2'd0;
            r_digits <= 16'h0000;
            r_value  <= 16'h0000;
            r_fv     <= 1'b0;
            r_seq    <= 1'b0;
            r_dec    <= 1'b0;
        end else begin
            r_state  <= w_n_state;
            r_exp    <= w_n_exp;
            r_last   <= w_n_last;
            r_digits <= w_n_digits;
            r_value  <= w_n_value;
            r_fv     <= w_n_fv;
            r_seq    <= w_n_seq;
            r_dec    <= w_n_dec;
        end
    end

    assign bus.value        = r_value;
    assign bus.frame_valid  = r_fv;
    assign bus.locked       = (r_state == S_TRACK);
    assign bus.seq_error    = r_seq;
    assign bus.decode_error = r_dec;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed vector bench for seven_seg_capture: scan table plus
// reset and reset-mid-frame sequences.
module tb_seven_seg_capture;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    seven_seg_capture_if u_if ();

    seven_seg_capture #(.STABLE_CYCLES(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  gl;
        int          hold;
        int          fv;
        logic [15:0] val;
        logic        lk;
        logic        se;
        logic        de;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] an, logic [6:0] gl, int hold,
                                int fv, logic [15:0] val,
                                logic lk, logic se, logic de);
        vec_t v;
        v.an = an; v.gl = gl; v.hold = hold; v.fv = fv;
        v.val = val; v.lk = lk; v.se = se; v.de = de;
        return v;
    endfunction

    // Drive one pattern (glyph given active-high) for hold cycles.
    task automatic apply(input logic [3:0] an, input logic [6:0] gl,
                         input int hold, output int pulses);
        pulses = 0;
        u_if.anode   = an;
        u_if.cathode = ~gl;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (u_if.frame_valid) pulses++;
        end
    endtask

    task automatic expect_out(input string name, input int fv_got,
                              input int fv_exp, input logic [15:0] v,
                              input logic lk, input logic se,
                              input logic de);
        n_vec++;
        if (fv_got != fv_exp || u_if.value !== v || u_if.locked !== lk ||
            u_if.seq_error !== se || u_if.decode_error !== de) begin
            n_bad++;
            $display("FAIL %s: got fv=%0d val=%h lk=%b se=%b de=%b, need fv=%0d val=%h lk=%b se=%b de=%b",
                     name, fv_got, u_if.value, u_if.locked, u_if.seq_error,
                     u_if.decode_error, fv_exp, v, lk, se, de);
        end
    endtask

    initial begin
        int p;
        n_vec = 0;
        n_bad = 0;

        // clean scan, glitch, 4-sample boundary commit
        tbl.push_back(mk(4'b1110, 7'h06, 8, 0, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(4'b1011, 7'h5B, 3, 0, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(4'b1101, 7'h5B, 4, 0, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(4'b1011, 7'h4F, 8, 0, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(4'b0111, 7'h66, 8, 1, 16'h4321, 1, 0, 0));
        tbl.push_back(mk(4'b1111, 7'h00, 8, 0, 16'h4321, 1, 0, 0));
        // out of order 0,1,3 then 8888
        tbl.push_back(mk(4'b1110, 7'h06, 8, 0, 16'h4321, 1, 0, 0));
        tbl.push_back(mk(4'b1101, 7'h5B, 8, 0, 16'h4321, 1, 0, 0));
        tbl.push_back(mk(4'b0111, 7'h66, 8, 0, 16'h4321, 0, 1, 0));
        tbl.push_back(mk(4'b1110, 7'h7F, 8, 0, 16'h4321, 1, 1, 0));
        tbl.push_back(mk(4'b1101, 7'h7F, 8, 0, 16'h4321, 1, 1, 0));
        tbl.push_back(mk(4'b1011, 7'h7F, 8, 0, 16'h4321, 1, 1, 0));
        tbl.push_back(mk(4'b0111, 7'h7F, 8, 1, 16'h8888, 1, 1, 0));
        // blank glyph on digit 2
        tbl.push_back(mk(4'b1110, 7'h3F, 8, 0, 16'h8888, 1, 1, 0));
        tbl.push_back(mk(4'b1101, 7'h06, 8, 0, 16'h8888, 1, 1, 0));
        tbl.push_back(mk(4'b1011, 7'h00, 8, 0, 16'h8888, 0, 1, 1));
        tbl.push_back(mk(4'b0111, 7'h66, 8, 0, 16'h8888, 0, 1, 1));
        tbl.push_back(mk(4'b1110, 7'h77, 8, 0, 16'h8888, 1, 1, 1));
        tbl.push_back(mk(4'b1101, 7'h7C, 8, 0, 16'h8888, 1, 1, 1));
        tbl.push_back(mk(4'b1011, 7'h39, 8, 0, 16'h8888, 1, 1, 1));
        tbl.push_back(mk(4'b0111, 7'h5E, 8, 1, 16'hDCBA, 1, 1, 1));
        // illegal anode
        tbl.push_back(mk(4'b0011, 7'h06, 8, 0, 16'hDCBA, 0, 1, 1));
        // re-commit of digit 0 with new glyph
        tbl.push_back(mk(4'b1110, 7'h79, 8, 0, 16'hDCBA, 1, 1, 1));
        tbl.push_back(mk(4'b1110, 7'h71, 8, 0, 16'hDCBA, 1, 1, 1));
        tbl.push_back(mk(4'b1101, 7'h7D, 8, 0, 16'hDCBA, 1, 1, 1));
        tbl.push_back(mk(4'b1011, 7'h6D, 8, 0, 16'hDCBA, 1, 1, 1));
        tbl.push_back(mk(4'b0111, 7'h07, 8, 1, 16'h756F, 1, 1, 1));
        // digit 0 out of order restarts the frame in TRACK
        tbl.push_back(mk(4'b1110, 7'h6F, 8, 0, 16'h756F, 1, 1, 1));
        tbl.push_back(mk(4'b1101, 7'h06, 8, 0, 16'h756F, 1, 1, 1));
        tbl.push_back(mk(4'b1110, 7'h3F, 8, 0, 16'h756F, 1, 1, 1));
        tbl.push_back(mk(4'b1101, 7'h5B, 8, 0, 16'h756F, 1, 1, 1));
        tbl.push_back(mk(4'b1011, 7'h4F, 8, 0, 16'h756F, 1, 1, 1));
        tbl.push_back(mk(4'b0111, 7'h66, 8, 1, 16'h4320, 1, 1, 1));

        rst          = 1'b1;
        u_if.anode   = 4'hF;
        u_if.cathode = 7'h7F;
        repeat (3) @(negedge clk);
        expect_out("reset", int'(u_if.frame_valid), 0, 16'h0000, 0, 0, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i].an, tbl[i].gl, tbl[i].hold, p);
            expect_out($sformatf("vec%0d", i), p, tbl[i].fv, tbl[i].val,
                       tbl[i].lk, tbl[i].se, tbl[i].de);
        end

        // reset after digit 2 commits
        apply(4'b1110, 7'h6F, 8, p);
        apply(4'b1101, 7'h06, 8, p);
        apply(4'b1011, 7'h5B, 8, p);
        #2 rst = 1'b1;
        #1 expect_out("async_rst", int'(u_if.frame_valid), 0, 16'h0000, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        apply(4'b0111, 7'h66, 8, p);
        expect_out("post_rst_d3", p, 0, 16'h0000, 0, 0, 0);
        apply(4'b1110, 7'h06, 8, p);
        expect_out("post_rst_d0", p, 0, 16'h0000, 1, 0, 0);
        apply(4'b1101, 7'h5B, 8, p);
        apply(4'b1011, 7'h4F, 8, p);
        apply(4'b0111, 7'h66, 8, p);
        expect_out("post_rst_frame", p, 1, 16'h4321, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
